// File: rtl/register_bank_mp.sv
// register_bank_mp: multi-read, dual-write register bank with load scoreboard.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module register_bank_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_busy,
  input  logic                     i_wa_en,
  input  logic [ADDR_W-1:0]        i_wa_addr,
  input  logic [DATA_W-1:0]        i_wa_data,
  input  logic                     i_wb_en,
  input  logic [ADDR_W-1:0]        i_wb_addr,
  input  logic [DATA_W-1:0]        i_wb_data,
  input  logic                     i_sb_set,
  input  logic [ADDR_W-1:0]        i_sb_addr,
  output logic                     o_any_busy
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pending;

  logic              wa_ok;
  logic              wb_ok;
  logic              sb_ok;
  logic [NREGS-1:0]  wa_hit;
  logic [NREGS-1:0]  wb_hit;
  logic [NREGS-1:0]  sb_hit;

  function automatic logic is_zero(
    input logic [ADDR_W-1:0] a
  );
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign wa_ok = i_wa_en  && !is_zero(i_wa_addr);
  assign wb_ok = i_wb_en  && !is_zero(i_wb_addr);
  assign sb_ok = i_sb_set && !is_zero(i_sb_addr);

  // One-hot decode of each write/scoreboard port.
  always_comb begin
    wa_hit = '0;
    wb_hit = '0;
    sb_hit = '0;
    for (int i = 0; i < NREGS; i++) begin
      wa_hit[i] = wa_ok && (i_wa_addr == ADDR_W'(i));
      wb_hit[i] = wb_ok && (i_wb_addr == ADDR_W'(i));
      sb_hit[i] = sb_ok && (i_sb_addr == ADDR_W'(i));
    end
  end

  // Register array; port B overrides port A on the same address.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wb_hit[i])
          regs[i] <= i_wb_data;
        else if (wa_hit[i])
          regs[i] <= i_wa_data;
      end
    end
  end

  // Pending scoreboard; a new load (set) beats a returning one (clear).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      pending <= '0;
    else
      pending <= (pending & ~wb_hit) | sb_hit;
  end

  // Combinational read ports, forced quiet during reset.
  always_comb begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              b;
    o_rd_data = '0;
    o_rd_busy = '0;
    a = '0;
    d = '0;
    b = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      a = i_rd_addr[k*ADDR_W +: ADDR_W];
      d = regs[a];
      b = pending[a];
`ifdef REGFILE_BYPASS_EN
      if (wb_ok && (i_wb_addr == a))
        d = i_wb_data;
      else if (wa_ok && (i_wa_addr == a))
        d = i_wa_data;
      if (wb_ok && (i_wb_addr == a) &&
          !(sb_ok && (i_sb_addr == a)))
        b = 1'b0;
`endif
      if (is_zero(a) || i_rst) begin
        d = '0;
        b = 1'b0;
      end
      o_rd_data[k*DATA_W +: DATA_W] = d;
      o_rd_busy[k] = b;
    end
  end

  assign o_any_busy = !i_rst && (|pending);

endmodule

// File: tb/tb_register_bank_mp.sv
// tb_register_bank_mp: directed checks for register_bank_mp.
// Expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_register_bank_mp;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [9:0]  i_rd_addr;
  logic [63:0] o_rd_data;
  logic [1:0]  o_rd_busy;
  logic        i_wa_en;
  logic [4:0]  i_wa_addr;
  logic [31:0] i_wa_data;
  logic        i_wb_en;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        i_sb_set;
  logic [4:0]  i_sb_addr;
  logic        o_any_busy;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  register_bank_mp dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rd_addr  (i_rd_addr),
    .o_rd_data  (o_rd_data),
    .o_rd_busy  (o_rd_busy),
    .i_wa_en    (i_wa_en),
    .i_wa_addr  (i_wa_addr),
    .i_wa_data  (i_wa_data),
    .i_wb_en    (i_wb_en),
    .i_wb_addr  (i_wb_addr),
    .i_wb_data  (i_wb_data),
    .i_sb_set   (i_sb_set),
    .i_sb_addr  (i_sb_addr),
    .o_any_busy (o_any_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic idle();
    i_wa_en  = 1'b0;
    i_wb_en  = 1'b0;
    i_sb_set = 1'b0;
  endtask

  task automatic rd(
    input logic [4:0] a0,
    input logic [4:0] a1
  );
    i_rd_addr = {a1, a0};
    #1;
  endtask

  task automatic wa(input logic [4:0] a, input logic [31:0] d);
    i_wa_en   = 1'b1;
    i_wa_addr = a;
    i_wa_data = d;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    i_wb_en   = 1'b1;
    i_wb_addr = a;
    i_wb_data = d;
  endtask

  task automatic sb(input logic [4:0] a);
    i_sb_set  = 1'b1;
    i_sb_addr = a;
  endtask

  initial begin
    i_rst = 1'b1;
    i_wa_addr = '0; i_wa_data = '0;
    i_wb_addr = '0; i_wb_data = '0;
    i_sb_addr = '0;
    idle();
    rd(5'd5, 5'd6);
    repeat (2) @(negedge i_clk);
    chk("rst_data", o_rd_data, 64'h0);
    chk("rst_busy", {62'h0, o_rd_busy}, 64'h0);
    chk("rst_any", {63'h0, o_any_busy}, 64'h0);
    i_rst = 1'b0;

    // write r5, load pending on r6, then reset clears both
    @(negedge i_clk);
    wa(5'd5, 32'hDEADBEEF);
    sb(5'd6);
    @(negedge i_clk);
    idle();
    rd(5'd5, 5'd6);
    chk("r5_wr", o_rd_data[31:0], 64'hDEADBEEF);
    chk("r6_busy", {62'h0, o_rd_busy}, 64'h2);
    chk("any_set", {63'h0, o_any_busy}, 64'h1);
    i_rst = 1'b1;
    #1;
    chk("rst_async", o_rd_data, 64'h0);
    @(negedge i_clk);
    i_rst = 1'b0;
    rd(5'd5, 5'd6);
    chk("r5_clr", o_rd_data, 64'h0);
    chk("busy_clr", {62'h0, o_rd_busy}, 64'h0);
    chk("any_clr", {63'h0, o_any_busy}, 64'h0);

    // dual-port conflict and independent writes
    @(negedge i_clk);
    wa(5'd7, 32'h11111111);
    wb(5'd7, 32'h22222222);
    @(negedge i_clk);
    wa(5'd3, 32'hA);
    wb(5'd4, 32'hB);
    rd(5'd7, 5'd7);
    chk("conf_r7", o_rd_data, {32'h22222222, 32'h22222222});
    @(negedge i_clk);
    idle();
    rd(5'd3, 5'd4);
    chk("r3_r4", o_rd_data, {32'hB, 32'hA});

    // zero register
    @(negedge i_clk);
    wa(5'd0, 32'hFFFFFFFF);
    wb(5'd0, 32'hFFFFFFFF);
    sb(5'd0);
    rd(5'd0, 5'd0);
    chk("r0_byp", o_rd_data, 64'h0);
    @(negedge i_clk);
    idle();
    rd(5'd0, 5'd0);
    chk("r0_data", o_rd_data, 64'h0);
    chk("r0_busy", {62'h0, o_rd_busy}, 64'h0);
    chk("r0_any", {63'h0, o_any_busy}, 64'h0);

    // scoreboard lifecycle on r9
    @(negedge i_clk);
    sb(5'd9);
    @(negedge i_clk);
    idle();
    rd(5'd9, 5'd9);
    chk("r9_busy", {62'h0, o_rd_busy}, 64'h3);
    chk("r9_any", {63'h0, o_any_busy}, 64'h1);
    wa(5'd9, 32'h77);
    @(negedge i_clk);
    idle();
    rd(5'd9, 5'd3);
    chk("wa_keeps", {62'h0, o_rd_busy}, 64'h1);
    chk("wa_r9", o_rd_data[31:0], 64'h77);
    wb(5'd9, 32'h1234);
    rd(5'd9, 5'd9);
    chk("wb_byp_busy", {62'h0, o_rd_busy},
        BYP ? 64'h0 : 64'h3);
    @(negedge i_clk);
    idle();
    rd(5'd9, 5'd9);
    chk("r9_free", {62'h0, o_rd_busy}, 64'h0);
    chk("r9_data", o_rd_data, {32'h1234, 32'h1234});
    chk("r9_any0", {63'h0, o_any_busy}, 64'h0);
    sb(5'd9);
    @(negedge i_clk);
    sb(5'd9);
    wb(5'd9, 32'h5678);
    rd(5'd9, 5'd9);
    chk("setclr_now", {62'h0, o_rd_busy}, 64'h3);
    @(negedge i_clk);
    idle();
    sb(5'd9);
    rd(5'd9, 5'd9);
    chk("setclr_busy", {62'h0, o_rd_busy}, 64'h3);
    chk("setclr_data", o_rd_data[31:0], 64'h5678);
    @(negedge i_clk);
    idle();
    rd(5'd9, 5'd9);
    chk("reset_keep", {62'h0, o_rd_busy}, 64'h3);
    wb(5'd9, 32'h5678);
    @(negedge i_clk);
    idle();
    rd(5'd9, 5'd9);
    chk("r9_done", {63'h0, o_any_busy}, 64'h0);

    // write-to-read latency and bypass priority
    @(negedge i_clk);
    wa(5'd12, 32'h55AA55AA);
    rd(5'd12, 5'd3);
    chk("byp_a", o_rd_data[31:0],
        BYP ? 64'h55AA55AA : 64'h0);
    @(negedge i_clk);
    idle();
    rd(5'd12, 5'd3);
    chk("r12_next", o_rd_data[31:0], 64'h55AA55AA);
    wa(5'd12, 32'h1);
    wb(5'd12, 32'h2);
    rd(5'd3, 5'd12);
    chk("byp_prio", o_rd_data[63:32],
        BYP ? 64'h2 : 64'h55AA55AA);
    @(negedge i_clk);
    idle();
    rd(5'd12, 5'd12);
    chk("prio_next", o_rd_data, {32'h2, 32'h2});

    // async reset in the middle of a write
    @(negedge i_clk);
    wa(5'd2, 32'h99);
    rd(5'd2, 5'd12);
    #2;
    i_rst = 1'b1;
    #1;
    chk("mid_rst_out", o_rd_data, 64'h0);
    @(negedge i_clk);
    idle();
    i_rst = 1'b0;
    rd(5'd2, 5'd12);
    chk("mid_rst_r2", o_rd_data, 64'h0);
    wa(5'd2, 32'h77);
    @(negedge i_clk);
    idle();
    rd(5'd2, 5'd2);
    chk("first_wr", o_rd_data[31:0], 64'h77);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/register_bank_mp.md
Name: register_bank_mp

Overview:
- Parametrised multi-port successor to the single-write register bank of the ARC MIPS core.
- Provides NUM_RD combinational read ports and two synchronous write ports:
  - port A: ALU writeback;
  - port B: load/memory writeback.
- Adds a per-register pending scoreboard so the hazard unit can stall on outstanding load results.
- Clears the whole array on reset and optionally hardwires register 0 to zero.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; number of registers NREGS = 2**ADDR_W.
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and ignores scoreboard sets.

Ports:
- i_clk  input  1  clock; all state changes on its rising edge.
- i_rst  input  1  reset; asynchronous and active-high.
- i_rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- o_rd_data  output  NUM_RD*DATA_W  packed read data, same packing as i_rd_addr.
- o_rd_busy  output  NUM_RD  pending bit of the addressed register, per read port.
- i_wa_en  input  1  write enable, port A.
- i_wa_addr  input  ADDR_W  write address, port A.
- i_wa_data  input  DATA_W  write data, port A.
- i_wb_en  input  1  write enable, port B; also clears pending.
- i_wb_addr  input  ADDR_W  write address, port B.
- i_wb_data  input  DATA_W  write data, port B.
- i_sb_set  input  1  mark register i_sb_addr pending (load issued).
- i_sb_addr  input  ADDR_W  scoreboard set address.
- o_any_busy  output  1  OR of all pending bits.

Behaviour:
- Reset (i_rst=1, asynchronous):
  - all NREGS registers cleared to 0 and all pending bits cleared;
  - while in reset: o_rd_data=0, o_rd_busy=0, o_any_busy=0;
  - reset asserted mid-write discards that write;
  - first write is accepted on the first rising edge after i_rst falls.
- Reads:
  - combinational and zero latency;
  - o_rd_data[k] = regs[i_rd_addr[k]];
  - ports are fully independent; any ports may share an address.
- Writes:
  - take effect at the rising edge and are visible on reads in the next cycle (base build).
  - Same-cycle A and B to the same address: port B data wins and port A is dropped.
  - A and B to different addresses: both committed.
- Zero register (ZERO_REG=1):
  - writes to address 0 are ignored;
  - i_sb_set to address 0 is ignored;
  - reads of address 0 return 0 with busy=0.
- Scoreboard:
  - pending[i_sb_addr] <= 1 when i_sb_set is high.
  - pending[i_wb_addr] <= 0 when i_wb_en is high.
  - Set and clear of the same address in the same cycle: set wins (a new load overrides the returning one).
  - A port A write does not affect pending.
  - o_rd_busy[k] = pending[i_rd_addr[k]]; o_any_busy = |pending.
  - Re-setting an already-pending register leaves it pending; no counting.
- Arithmetic: none; data is stored verbatim. Addresses always index within NREGS, so no out-of-range case exists.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (same-cycle bypass):
  - if a read address matches an enabled write address this cycle, o_rd_data returns the incoming write data;
  - port B takes priority over port A, matching the write priority;
  - o_rd_busy[k] reads 0 when i_wb_en hits the same address and i_sb_set is not targeting it;
  - address 0 is never bypassed when ZERO_REG=1.
- Undefined:
  - reads return array contents only, with the one-cycle write-to-read latency described above;
  - busy reflects registered pending bits only.

Test Plan:
- Reset clears state: write 0xDEADBEEF to r5 via A, then pulse i_rst for 1 cycle -> read r5 = 0x00000000, o_any_busy = 0.
- Dual-port conflict: same cycle A writes r7 = 0x11111111 and B writes r7 = 0x22222222 -> r7 = 0x22222222; also A r3 = 0xA, B r4 = 0xB -> r3 = 0xA, r4 = 0xB.
- Zero register: write r0 = 0xFFFFFFFF and i_sb_set r0 -> read r0 = 0, busy = 0 on every port.
- Scoreboard lifecycle:
  - i_sb_set r9 -> next cycle o_rd_busy = 1 on any port reading r9, o_any_busy = 1;
  - B writes r9 = 0x1234 -> next cycle busy = 0 and r9 = 0x1234;
  - same-cycle set and clear of r9 -> busy stays 1.
- Bypass (REGFILE_BYPASS_EN defined): read r12 while A writes r12 = 0x55AA55AA -> same-cycle o_rd_data = 0x55AA55AA. Without the macro: old value this cycle, new value next cycle.
- Async reset mid-write: assert i_rst between clock edges while i_wa_en = 1 to r2 = 0x99 -> outputs go to 0 immediately and r2 = 0 after release.
